// File: rtl/seg_scan_driver_if.sv
// Bundle of display-side signals for the four-digit 7-segment scan driver.
// The master drives the BCD digits and display controls and observes the LED lines.
interface seg_scan_driver_if;
  logic [7:0] bcd_min;
  logic [7:0] bcd_sec;
  logic [3:0] blink_en;
  logic       lz_sup;
  logic       colon_on;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic       frame_done;

  modport master (
    output bcd_min, bcd_sec, blink_en, lz_sup, colon_on,
    input  an_n, seg_n, dp_n, frame_done
  );

  modport slave (
    input  bcd_min, bcd_sec, blink_en, lz_sup, colon_on,
    output an_n, seg_n, dp_n, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed MM:SS 7-segment driver with anti-ghosting blanking, per-digit blink
// and leading-zero suppression. Inputs are snapshotted once per frame.
module seg_scan_driver #(
  parameter int SCAN_DIV     = 1000,
  parameter int GHOST_CYC    = 4,
  parameter int BLINK_FRAMES = 64
) (
  input logic             clk,
  input logic             rst_n,
  seg_scan_driver_if.slave bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GHOST = CNT_W'(GHOST_CYC);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digitT;

  digitT            digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FRM_W-1:0] frameCnt_q, frameCnt_d;
  logic             blinkPhase_q, blinkPhase_d;

  logic [7:0]       snapMin_q, snapMin_d;
  logic [7:0]       snapSec_q, snapSec_d;
  logic [3:0]       snapBlink_q, snapBlink_d;
  logic             snapLz_q, snapLz_d;
  logic             snapColon_q, snapColon_d;

  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frameDone_q, frameDone_d;

  logic             cntLast;
  logic             frameEnd;
  logic [3:0]       nibble;
  logic             blanked;
  logic             anodeOn;

  function automatic logic [6:0] decodeNibble(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q      <= DIG0;
      cnt_q        <= '0;
      frameCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
      snapMin_q    <= '0;
      snapSec_q    <= '0;
      snapBlink_q  <= '0;
      snapLz_q     <= 1'b0;
      snapColon_q  <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frameDone_q  <= 1'b0;
    end else begin
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      frameCnt_q   <= frameCnt_d;
      blinkPhase_q <= blinkPhase_d;
      snapMin_q    <= snapMin_d;
      snapSec_q    <= snapSec_d;
      snapBlink_q  <= snapBlink_d;
      snapLz_q     <= snapLz_d;
      snapColon_q  <= snapColon_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frameDone_q  <= frameDone_d;
    end
  end

  // Scan sequencing, frame-coherent snapshot and blink phase.
  always_comb begin
    cntLast      = (cnt_q == CNT_LAST);
    frameEnd     = cntLast && (digit_q == DIG3);
    digit_d      = digit_q;
    cnt_d        = cntLast ? '0 : cnt_q + CNT_W'(1);
    frameCnt_d   = frameCnt_q;
    blinkPhase_d = blinkPhase_q;
    snapMin_d    = snapMin_q;
    snapSec_d    = snapSec_q;
    snapBlink_d  = snapBlink_q;
    snapLz_d     = snapLz_q;
    snapColon_d  = snapColon_q;

    if (cntLast) begin
      case (digit_q)
        DIG0:    digit_d = DIG1;
        DIG1:    digit_d = DIG2;
        DIG2:    digit_d = DIG3;
        default: digit_d = DIG0;
      endcase
    end

    if (frameEnd) begin
      if (frameCnt_q == FRM_LAST) begin
        frameCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        frameCnt_d = frameCnt_q + FRM_W'(1);
      end
    end

    if ((digit_q == DIG0) && (cnt_q == '0)) begin
      snapMin_d   = bus.bcd_min;
      snapSec_d   = bus.bcd_sec;
      snapBlink_d = bus.blink_en;
      snapLz_d    = bus.lz_sup;
      snapColon_d = bus.colon_on;
    end
  end

  // Output image for the next cycle; the anode is off during ghost cycles and blanking.
  always_comb begin
    case (digit_q)
      DIG0:    nibble = snapSec_q[3:0];
      DIG1:    nibble = snapSec_q[7:4];
      DIG2:    nibble = snapMin_q[3:0];
      default: nibble = snapMin_q[7:4];
    endcase

    blanked = (snapBlink_q[digit_q] && blinkPhase_q) ||
              ((digit_q == DIG3) && snapLz_q && (nibble == 4'd0));
    anodeOn = (cnt_q >= CNT_GHOST) && !blanked;

    an_d        = 4'hF;
    seg_d       = 7'h7F;
    dp_d        = 1'b1;
    frameDone_d = frameEnd;

    if (anodeOn) begin
      an_d[digit_q] = 1'b0;
      seg_d         = decodeNibble(nibble);
      dp_d          = !((digit_q == DIG2) && snapColon_q);
    end
  end

  assign bus.an_n       = an_q;
  assign bus.seg_n      = seg_q;
  assign bus.dp_n       = dp_q;
  assign bus.frame_done = frameDone_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=8, GHOST_CYC=2, BLINK_FRAMES=2.
// Each output cycle of a digit slot is compared against hand-derived segment codes.
module tb_seg_scan_driver;

  localparam int SD = 8;
  localparam int GC = 2;
  localparam int BF = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  seg_scan_driver_if bus ();

  seg_scan_driver #(
    .SCAN_DIV    (SD),
    .GHOST_CYC   (GC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [7:0] mins, input logic [7:0] secs,
                               input logic [3:0] blink, input logic lz, input logic colon);
    bus.bcd_min  = mins;
    bus.bcd_sec  = secs;
    bus.blink_en = blink;
    bus.lz_sup   = lz;
    bus.colon_on = colon;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expAn, input logic [6:0] expSeg,
                             input logic expDp, input logic expFd);
    total++;
    assert (bus.an_n === expAn) else begin
      bad++;
      $error("FAIL %s an_n got=%h want=%h", tag, bus.an_n, expAn);
    end
    total++;
    assert (bus.seg_n === expSeg) else begin
      bad++;
      $error("FAIL %s seg_n got=%h want=%h", tag, bus.seg_n, expSeg);
    end
    total++;
    assert (bus.dp_n === expDp) else begin
      bad++;
      $error("FAIL %s dp_n got=%b want=%b", tag, bus.dp_n, expDp);
    end
    total++;
    assert (bus.frame_done === expFd) else begin
      bad++;
      $error("FAIL %s frame_done got=%b want=%b", tag, bus.frame_done, expFd);
    end
  endtask

  // Steps through slot positions first..last of digit d, one output cycle each.
  task automatic checkCycles(input string tag, input int d, input logic [6:0] seg,
                             input logic vis, input logic dpOn, input int first, input int last);
    logic       on;
    logic [3:0] eAn;
    logic [6:0] eSeg;
    logic       eDp;
    logic       eFd;
    for (int p = first; p <= last; p++) begin
      @(posedge clk);
      @(negedge clk);
      on   = vis && (p >= GC);
      eAn  = on ? (4'hF ^ (4'b0001 << d)) : 4'hF;
      eSeg = on ? seg : 7'h7F;
      eDp  = !(on && dpOn);
      eFd  = (d == 3) && (p == SD - 1);
      checkOutput($sformatf("%s d%0d p%0d", tag, d, p), eAn, eSeg, eDp, eFd);
    end
  endtask

  task automatic checkFrame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] visMask, input logic dpOn);
    checkCycles(tag, 0, s0, visMask[0], 1'b0, 0, SD - 1);
    checkCycles(tag, 1, s1, visMask[1], 1'b0, 0, SD - 1);
    checkCycles(tag, 2, s2, visMask[2], dpOn, 0, SD - 1);
    checkCycles(tag, 3, s3, visMask[3], 1'b0, 0, SD - 1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    applyStimulus(8'h12, 8'h34, 4'b0000, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
    rst_n = 1'b1;

    // Frame 0 shows 12:34; a seconds change in the digit-1 dwell must not leak in.
    checkCycles("f0", 0, 7'h19, 1'b1, 1'b0, 0, SD - 1);
    checkCycles("f0", 1, 7'h30, 1'b1, 1'b0, 0, 1);
    applyStimulus(8'h12, 8'h56, 4'b0000, 1'b0, 1'b0);
    checkCycles("f0", 1, 7'h30, 1'b1, 1'b0, 2, SD - 1);
    checkCycles("f0", 2, 7'h24, 1'b1, 1'b0, 0, SD - 1);
    checkCycles("f0", 3, 7'h79, 1'b1, 1'b0, 0, SD - 1);

    checkFrame("f1", 7'h02, 7'h12, 7'h24, 7'h79, 4'hF, 1'b0);

    applyStimulus(8'h05, 8'h56, 4'b0000, 1'b1, 1'b0);
    checkFrame("lz1", 7'h02, 7'h12, 7'h12, 7'h7F, 4'b0111, 1'b0);

    applyStimulus(8'h05, 8'h56, 4'b0000, 1'b0, 1'b0);
    checkFrame("lz0", 7'h02, 7'h12, 7'h12, 7'h40, 4'hF, 1'b0);

    applyStimulus(8'h05, 8'hA9, 4'b0000, 1'b0, 1'b1);
    checkFrame("dash", 7'h10, 7'h3F, 7'h12, 7'h40, 4'hF, 1'b1);

    // Reset while frame_done is high, then blink digit 0 with two-frame half-period.
    applyStimulus(8'h12, 8'h34, 4'b0001, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1 checkOutput("blkrst", 4'hF, 7'h7F, 1'b1, 1'b0);
    #1 rst_n = 1'b1;
    checkFrame("blk0", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF, 1'b0);
    checkFrame("blk1", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF, 1'b0);
    checkFrame("blk2", 7'h19, 7'h30, 7'h24, 7'h79, 4'b1110, 1'b0);
    checkFrame("blk3", 7'h19, 7'h30, 7'h24, 7'h79, 4'b1110, 1'b0);
    checkFrame("blk4", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF, 1'b0);
    checkFrame("blk5", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF, 1'b0);

    // Abort the scan inside an active digit-2 dwell and confirm a clean restart.
    applyStimulus(8'h12, 8'h34, 4'b0000, 1'b0, 1'b1);
    checkCycles("pre", 0, 7'h19, 1'b1, 1'b0, 0, SD - 1);
    checkCycles("pre", 1, 7'h30, 1'b1, 1'b0, 0, SD - 1);
    checkCycles("pre", 2, 7'h24, 1'b1, 1'b1, 0, 3);
    rst_n = 1'b0;
    #1 checkOutput("midrst", 4'hF, 7'h7F, 1'b1, 1'b0);
    #1 rst_n = 1'b1;
    checkFrame("post", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clk cycles each digit is dwelled on (legal >= GHOST_CYC+2).
REQ-002 Parameter GHOST_CYC, default 4, cycles at the start of each dwell with all anodes off (anti-ghosting; legal >= 1).
REQ-003 Parameter BLINK_FRAMES, default 64, full scan frames per blink half-period (legal >= 1).
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 bcd_min  input  8  minutes as two BCD nibbles, [7:4] tens, [3:0] ones, from the binary-to-BCD stage.
REQ-007 bcd_sec  input  8  seconds as two BCD nibbles, same layout.
REQ-008 blink_en  input  4  per-digit blink enable, bit i = digit i.
REQ-009 lz_sup  input  1  suppress digit 3 when its nibble is 0.
REQ-010 colon_on  input  1  drive decimal point on digit 2.
REQ-011 an_n  output  4  active-low anode select, bit i = digit i.
REQ-012 seg_n  output  7  active-low segments, bit0=a ... bit6=g.
REQ-013 dp_n  output  1  active-low decimal point.
REQ-014 frame_done  output  1  one-cycle pulse at end of each 4-digit frame.

Function
REQ-015 Digit map: 0=bcd_sec[3:0], 1=bcd_sec[7:4], 2=bcd_min[3:0], 3=bcd_min[7:4]; scan order 0,1,2,3, wrap to 0.
REQ-016 Dwell counter cnt counts 0..SCAN_DIV-1; at SCAN_DIV-1 it returns to 0 and digit index advances (3 -> 0).
REQ-017 Snapshot registers SHALL load bcd_min, bcd_sec, blink_en, lz_sup, colon_on on every cycle where digit==0 and cnt==0; display uses only snapshot values (frame-coherent).
REQ-018 All outputs registered: outputs in cycle t+1 are a function of (digit, cnt, snapshot, blink phase) in cycle t.
REQ-019 an_n = 4'hF while cnt < GHOST_CYC; otherwise only bit[digit] low, unless the digit is blanked.
REQ-020 Digit blanked (an_n = 4'hF for whole dwell) when blink_en[digit]=1 and blink phase=1, or digit==3 with lz_sup=1 and nibble==0.
REQ-021 Decode of valid nibble 0-9, seg_n: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-022 Nibble 10-15 SHALL display dash: seg_n=7'h3F.
REQ-023 seg_n = 7'h7F whenever an_n = 4'hF.
REQ-024 dp_n = 0 only when digit==2, anode active, colon_on snapshot=1; else 1.
REQ-025 Frame counter counts completed frames 0..BLINK_FRAMES-1; on wrap, blink phase toggles.
REQ-026 frame_done = 1 for exactly the cycle after digit==3 and cnt==SCAN_DIV-1.
REQ-027 Input changes mid-frame SHALL NOT alter displayed values until next snapshot.

Reset
REQ-028 rst_n low asynchronously forces digit=0, cnt=0, frame counter=0, blink phase=0, snapshots=0, an_n=4'hF, seg_n=7'h7F, dp_n=1, frame_done=0.
REQ-029 Reset asserted mid-dwell or mid-frame SHALL abort the scan; first rising edge after release loads snapshot (digit 0, cnt 0).

Verification (SCAN_DIV=8, GHOST_CYC=2, BLINK_FRAMES=2)
REQ-030 bcd_min=8'h12, bcd_sec=8'h34, release reset -> an_n walks E,D,B,7 with 8-cycle dwell, first 2 cycles F; seg_n 19,30,24,79 respectively.
REQ-031 bcd_sec changed 8'h34->8'h56 at cycle 10 -> displayed digits unchanged until next frame; frame_done pulses once per 32 cycles.
REQ-032 bcd_min=8'h05, lz_sup=1 -> digit 3 anode never low, seg_n=7'h7F in its slot; lz_sup=0 -> digit 3 shows 7'h40.
REQ-033 blink_en=4'b0001 -> digit 0 visible frames 0-1, blanked frames 2-3, visible 4-5.
REQ-034 bcd_sec=8'hA9 -> digit 1 seg_n=7'h3F, digit 0 seg_n=7'h10; colon_on=1 -> dp_n=0 only in digit 2 active cycles.
REQ-035 rst_n pulsed low during digit 2 dwell -> same cycle an_n=4'hF, seg_n=7'h7F; scan restarts at digit 0 with 2 ghost cycles.
